// File: rtl/cm150_scan_pkg.sv
// Shared constants and state encoding for the CM150 scan controller.
// Imported by the controller top and its settle timer.
package cm150_scan_pkg;

    localparam int NCH   = 16;
    localparam int SEL_W = 4;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        SCAN  = 2'd2
    } state_t;

endpackage

// File: rtl/cm150_settle_timer.sv
// Per-channel settle counter for the CM150 scan controller.
// Ticks on the cycle whose closing edge samples the mux output.
module cm150_settle_timer
    import cm150_scan_pkg::*;
#(
    parameter int SETTLE = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic tick
);

    logic [CNT_W-1:0] cnt;

    assign tick = run && (cnt == CNT_W'(SETTLE));

    // count hold cycles; restart after each sample or outside a scan
    always_ff @(posedge clk) begin
        if (rst || !run || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/cm150_scan_ctrl.sv
// Scan sequencer for the CM150 16:1 mux: disabled-output check,
// then 16 settled samples delivered as one registered word.
module cm150_scan_ctrl
    import cm150_scan_pkg::*;
#(
    parameter int SETTLE = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cont,
    input  logic             mux_v,
    output logic [SEL_W-1:0] sel,
    output logic             en_n,
    output logic             busy,
    output logic             done,
    output logic [NCH-1:0]   word,
    output logic             word_valid,
    output logic             stuck_err
);

    state_t           state;
    logic [SEL_W-1:0] ch;
    logic [NCH-1:0]   shadow;
    logic             tick;
    logic             last;

    assign last = tick && (ch == SEL_W'(NCH - 1));

    cm150_settle_timer #(
        .SETTLE (SETTLE)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .run  (state == SCAN),
        .tick (tick)
    );

    // shadow collects samples; partial scans are discarded on reset
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow <= '0;
        end else if (state == SCAN && tick) begin
            shadow[ch] <= mux_v;
        end
    end

    // sequencing FSM and all registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ch         <= '0;
            sel        <= '0;
            en_n       <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            word       <= '0;
            word_valid <= 1'b0;
            stuck_err  <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state      <= CHECK;
                        busy       <= 1'b1;
                        word_valid <= 1'b0;
                        stuck_err  <= 1'b0;
                    end
                end
                CHECK: begin
                    // output is forced high while disabled
                    stuck_err  <= ~mux_v;
                    word_valid <= 1'b0;
                    state      <= SCAN;
                    ch         <= '0;
                    sel        <= '0;
                    en_n       <= 1'b0;
                end
                SCAN: begin
                    if (last) begin
                        word       <= {mux_v, shadow[NCH-2:0]};
                        word_valid <= 1'b1;
                        done       <= 1'b1;
                        en_n       <= 1'b1;
                        sel        <= '0;
                        ch         <= '0;
                        if (cont) begin
                            state <= CHECK;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else if (tick) begin
                        // select moves with the sample edge
                        ch  <= ch + 1'b1;
                        sel <= ch + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cm150_scan_ctrl.sv
// Bench for cm150_scan_ctrl: two instances (SETTLE 2 and 0) on a CM150
// mux model, checked each cycle against a timing-arithmetic reference.
module tb_cm150_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        cont;
    logic        stuck;
    logic [15:0] din;

    logic [3:0]  sel_o  [2];
    logic        en_o   [2];
    logic        busy_o [2];
    logic        done_o [2];
    logic [15:0] word_o [2];
    logic        wv_o   [2];
    logic        err_o  [2];
    logic        mux_v  [2];

    int vectors = 0;
    int errs    = 0;
    int edge_n  = 0;
    bit chk_on  = 0;

    always #5 clk = ~clk;

    // CM150 behaviour: disabled forces 1; stuck mode forces 0
    assign mux_v[0] = stuck ? 1'b0 : (en_o[0] ? 1'b1 : din[sel_o[0]]);
    assign mux_v[1] = stuck ? 1'b0 : (en_o[1] ? 1'b1 : din[sel_o[1]]);

    cm150_scan_ctrl #(.SETTLE(2)) dut0 (
        .clk(clk), .rst(rst), .start(start), .cont(cont),
        .mux_v(mux_v[0]), .sel(sel_o[0]), .en_n(en_o[0]),
        .busy(busy_o[0]), .done(done_o[0]), .word(word_o[0]),
        .word_valid(wv_o[0]), .stuck_err(err_o[0])
    );

    cm150_scan_ctrl #(.SETTLE(0)) dut1 (
        .clk(clk), .rst(rst), .start(start), .cont(cont),
        .mux_v(mux_v[1]), .sel(sel_o[1]), .en_n(en_o[1]),
        .busy(busy_o[1]), .done(done_o[1]), .word(word_o[1]),
        .word_valid(wv_o[1]), .stuck_err(err_o[1])
    );

    // reference: m_p = edges since the accepting edge E0
    int          sv [2] = '{2, 0};
    bit          m_act  [2];
    int          m_p    [2];
    logic [15:0] m_sh   [2];
    logic [15:0] m_word [2];
    bit          m_wv   [2];
    bit          m_err  [2];
    bit          m_done [2];

    function automatic void model_step(input int i);
        int k;
        if (rst) begin
            m_act[i] = 0; m_p[i] = 0; m_sh[i] = '0; m_word[i] = '0;
            m_wv[i] = 0; m_err[i] = 0; m_done[i] = 0;
            return;
        end
        m_done[i] = 0;
        if (!m_act[i]) begin
            if (start) begin
                m_act[i] = 1; m_p[i] = 0; m_wv[i] = 0; m_err[i] = 0;
            end
            return;
        end
        m_p[i]++;
        if (m_p[i] == 1) begin
            m_err[i] = stuck;
            m_wv[i]  = 0;
        end else if ((m_p[i] - 1) % (sv[i] + 1) == 0) begin
            k = (m_p[i] - 1) / (sv[i] + 1) - 1;
            m_sh[i][k] = stuck ? 1'b0 : din[k];
            if (k == 15) begin
                m_word[i] = m_sh[i];
                m_wv[i] = 1; m_done[i] = 1;
                if (cont) m_p[i] = 0;
                else m_act[i] = 0;
            end
        end
    endfunction

    always @(posedge clk) begin
        model_step(0);
        model_step(1);
        edge_n++;
    end

    // per-cycle compare of every output against the reference
    always @(negedge clk) begin
        if (chk_on) begin
            for (int i = 0; i < 2; i++) begin
                logic [24:0] got, exp;
                logic [3:0]  esel;
                bit          scan;
                scan = m_act[i] && m_p[i] >= 1;
                esel = scan ? 4'((m_p[i] - 1) / (sv[i] + 1)) : 4'd0;
                got = {sel_o[i], en_o[i], busy_o[i], done_o[i],
                       word_o[i], wv_o[i], err_o[i]};
                exp = {esel, !scan, m_act[i], m_done[i],
                       m_word[i], m_wv[i], m_err[i]};
                vectors++;
                if (got !== exp) begin
                    errs++;
                    $display("FAIL cyc inst%0d edge%0d got=%h exp=%h",
                             i, edge_n, got, exp);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic pulse_start(output int e0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        e0 = edge_n;
    endtask

    task automatic wait_done(input int i, output int e);
        int n = 0;
        @(negedge clk);
        while (!done_o[i] && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!done_o[i]) begin
            vectors++; errs++;
            $display("FAIL done_timeout inst%0d", i);
        end
        e = edge_n;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy_o[0] || busy_o[1]) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (busy_o[0] || busy_o[1]) begin
            vectors++; errs++;
            $display("FAIL idle_timeout");
        end
    endtask

    initial begin
        int e0, e, e1;
        rst = 1'b1; start = 1'b0; cont = 1'b0; stuck = 1'b0;
        din = 16'hA5C3;
        repeat (3) @(negedge clk);
        chk_on = 1;
        chk("rst_word", 32'(word_o[0]), 32'h0);
        chk("rst_en_n", 32'(en_o[0]), 32'h1);
        chk("rst_busy", 32'(busy_o[1]), 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // plain scan, both settle values
        pulse_start(e0);
        wait_done(1, e);
        chk("s0_done_edge", 32'(e - e0), 32'd17);
        chk("s0_word", 32'(word_o[1]), 32'hA5C3);
        wait_done(0, e);
        chk("s2_done_edge", 32'(e - e0), 32'd49);
        chk("s2_word", 32'(word_o[0]), 32'hA5C3);
        chk("s2_valid", 32'(wv_o[0]), 32'h1);
        chk("s2_err", 32'(err_o[0]), 32'h0);
        wait_idle();

        // stuck-low output
        stuck = 1'b1;
        pulse_start(e0);
        @(negedge clk);
        chk("stuck_err", 32'(err_o[0]), 32'h1);
        wait_done(0, e);
        chk("stuck_word", 32'(word_o[0]), 32'h0);
        stuck = 1'b0;
        wait_idle();

        // single-bit pattern
        din = 16'h0001;
        pulse_start(e0);
        wait_done(1, e);
        chk("s0_edge_b", 32'(e - e0), 32'd17);
        chk("s0_word_b", 32'(word_o[1]), 32'h0001);
        wait_idle();

        // reset during channel 7
        din = 16'h3C5A;
        pulse_start(e0);
        while (edge_n < e0 + 22) @(negedge clk);
        chk("ch7_sel", 32'(sel_o[0]), 32'h7);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_busy", 32'(busy_o[0]), 32'h0);
        chk("mid_rst_sel", 32'(sel_o[0]), 32'h0);
        pulse_start(e0);
        wait_done(0, e);
        chk("post_rst_word", 32'(word_o[0]), 32'h3C5A);
        wait_idle();

        // continuous mode with data change between scans
        din = 16'h00FF;
        cont = 1'b1;
        pulse_start(e0);
        wait_done(0, e1);
        chk("cont_word1", 32'(word_o[0]), 32'h00FF);
        chk("cont_busy", 32'(busy_o[0]), 32'h1);
        din = 16'hFF00;
        wait_done(0, e);
        chk("cont_gap", 32'(e - e1), 32'd49);
        chk("cont_word2", 32'(word_o[0]), 32'hFF00);
        cont = 1'b0;
        @(negedge clk);
        wait_idle();

        // start while busy ignored, start in done cycle accepted
        din = 16'h5A5A;
        pulse_start(e0);
        repeat (10) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(0, e);
        chk("busy_start_e", 32'(e - e0), 32'd49);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("done_start_busy", 32'(busy_o[0]), 32'h1);
        chk("done_start_en", 32'(en_o[0]), 32'h1);
        wait_idle();

        // randomized traffic
        for (int n = 0; n < 4000; n++) begin
            start = ($urandom % 16) == 0;
            cont  = ($urandom % 6) == 0;
            if (($urandom % 20) == 0) din = 16'($urandom);
            if (($urandom % 60) == 0) stuck = ~stuck;
            rst = ($urandom % 700) == 0;
            @(negedge clk);
        end
        rst = 1'b0;
        start = 1'b0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule

// File: doc/cm150_scan_ctrl.md
# cm150_scan_ctrl

Sequencer that drives the select and enable lines of the CM150 16:1 multiplexer and consumes its single-bit output. On each scan it steps through channels 0–15 (data inputs a..p), waits a programmable settle time per channel, samples the mux output, and presents the 16 samples as one registered word. Before each scan it performs a disabled-output check to detect a stuck-low mux output.

## Interface
- `SETTLE`, default 2: extra hold cycles per channel before sampling; legal range 0..15.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `start`  in  1  request a scan; sampled only in IDLE.
- `cont`  in  1  continuous mode; sampled at scan completion.
- `mux_v`  in  1  CM150 output `v`.
- `sel`  out  4  CM150 select: `sel[0]`→q, `sel[1]`→r, `sel[2]`→s, `sel[3]`→t.
- `en_n`  out  1  CM150 `u`; active-low enable.
- `busy`  out  1  scan in progress (CHECK or SCAN).
- `done`  out  1  one-cycle pulse after the last channel is captured.
- `word`  out  16  captured samples; `word[k]` = channel k (input a = bit 0 … p = bit 15).
- `word_valid`  out  1  `word` holds a complete scan.
- `stuck_err`  out  1  mux output read 0 while disabled in the last CHECK.

## Operation
- Mux contract: with `en_n`=0, `mux_v` = selected input; with `en_n`=1, `mux_v` is forced to 1.
- States: IDLE, CHECK, SCAN.
- IDLE: `en_n`=1, `sel`=0, `busy`=0. When `start`=1: go to CHECK, clear `word_valid` and `stuck_err`.
- CHECK, one cycle, `en_n`=1: at its closing edge, set `stuck_err` = ~`mux_v`. Then go to SCAN with ch=0, cnt=0. The scan proceeds regardless of `stuck_err`.
- SCAN, `en_n`=0, `sel`=ch. On each edge:
  - If cnt==`SETTLE`: write `mux_v` into shadow bit ch, ch+1, cnt=0.
  - Otherwise: cnt+1.
- On the edge that captures ch 15:
  - `word` ← shadow including this sample; `word_valid`←1; `done`←1 for the next cycle.
  - If `cont`=1: go to CHECK, clearing `word_valid` and `stuck_err` one cycle later as in IDLE entry. Otherwise go to IDLE.
- `word` is stable for the whole scan. It updates only at completion.
- `start` while busy is ignored. In IDLE, `start` in the `done` cycle is accepted.
- ch is 4 bits and does not wrap mid-scan. cnt is 4 bits.

## Timing
- Reset values: `sel`=0, `en_n`=1, `busy`=0, `done`=0, `word`=0, `word_valid`=0, `stuck_err`=0, state IDLE, ch=0, cnt=0.
- Reset mid-scan: returns to IDLE on the next edge and discards the partial shadow.
- Label the edge that accepts `start` E0.
  - CHECK occupies E0..E1.
  - Channel k is sampled at edge E1+(k+1)(`SETTLE`+1).
  - `done` is high in the cycle after E1+16(`SETTLE`+1). With `SETTLE`=2 that is the cycle after E49.
- `sel` changes on the same edge as the previous sample. No cycle has `en_n`=0 with a stale `sel`.
- All outputs are registered. No combinational path from `mux_v` to any output.
- `busy` falls in the same cycle `done` rises. In `cont` mode `busy` stays high and `done` still pulses.

## Structure
- Package `cm150_scan_pkg`: state enum {IDLE, CHECK, SCAN}, `NCH`=16, `SEL_W`=4, `CNT_W`=4.
- One natural sub-module: `cm150_settle_timer`. It holds the cnt register and emits a `tick` when cnt==`SETTLE`.
- The FSM, channel counter and shadow register stay in the top module.

## Test plan
- Drive the real CM150 netlist with inputs a..p = 16'hA5C3, `u`=`en_n`, `SETTLE`=2, pulse `start` → `done` in the cycle after E49, `word`=16'hA5C3, `word_valid`=1, `stuck_err`=0.
- Replace `mux_v` with a constant 0 → `stuck_err`=1 after E1, `word`=16'h0000 at `done`.
- `SETTLE`=0 with inputs 16'h0001 → `sel` increments every cycle, `done` in the cycle after E17, `word`=16'h0001.
- Assert `rst` during channel 7 → next cycle all outputs equal their reset values. A new `start` then completes a normal scan with correct `word`.
- `cont`=1 with inputs changed from 16'h00FF to 16'hFF00 mid-run → back-to-back `done` pulses; the second scan captures 16'hFF00 with no IDLE gap.
- Pulse `start` during SCAN and again in the `done` cycle → the first is ignored; the second starts CHECK at the next edge.
